// File: rtl/mono_video_pkg.sv
// mono_video_pkg: shared types and palette helpers for the mono video mapper
package mono_video_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    function automatic longint default_ramp(longint i, longint lb, longint ob);
        return (i * ((longint'(1) << ob) - 1)) / ((longint'(1) << lb) - 1);
    endfunction

endpackage

// File: rtl/mono_pal_bank.sv
// mono_pal_bank: shadow/active palette registers with vblank-edge commit
//   clk_sys, Reset_I (async active-low)
//   vb_edge_i                rising edge of vblank, the commit point
//   pal_wr_i/addr_i/data_i   shadow write port, one entry per cycle
//   rd_level_i -> rd_rgb_o   active palette lookup
//   pending_o                shadow holds uncommitted writes
module mono_pal_bank
    import mono_video_pkg::*;
#(
    parameter int LEVEL_BITS = 2,
    parameter int OUT_BITS   = 8
) (
    input  logic                  clk_sys,
    input  logic                  Reset_I,
    input  logic                  vb_edge_i,
    input  logic                  pal_wr_i,
    input  logic [LEVEL_BITS-1:0] pal_addr_i,
    input  logic [3*OUT_BITS-1:0] pal_data_i,
    input  logic [LEVEL_BITS-1:0] rd_level_i,
    output logic [3*OUT_BITS-1:0] rd_rgb_o,
    output logic                  pending_o
);
    localparam int NE = 2**LEVEL_BITS;
    localparam int RW = 3*OUT_BITS;

    logic [RW-1:0] ramp     [NE];
    logic [RW-1:0] shadow_q [NE];
    logic [RW-1:0] shadow_d [NE];
    logic [RW-1:0] active_q [NE];
    logic [RW-1:0] active_d [NE];
    logic          pending_q, pending_d, commit;

    for (genvar g = 0; g < NE; g++) begin : g_ramp
        assign ramp[g] = {3{OUT_BITS'(default_ramp(g, LEVEL_BITS, OUT_BITS))}};
    end

    // A write landing on the edge cycle is bypassed so it commits with the rest.
    always_comb begin
        shadow_d = shadow_q;
        if (pal_wr_i) shadow_d[pal_addr_i] = pal_data_i;
        commit    = vb_edge_i & (pending_q | pal_wr_i);
        active_d  = active_q;
        if (commit) active_d = shadow_d;
        pending_d = ~commit & (pending_q | pal_wr_i);
    end

    always_ff @(posedge clk_sys or negedge Reset_I) begin
        if (!Reset_I) begin
            shadow_q  <= ramp;
            active_q  <= ramp;
            pending_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
        end
    end

    assign rd_rgb_o  = active_q[rd_level_i];
    assign pending_o = pending_q;

endmodule

// File: rtl/mono_video_mapper.sv
// mono_video_mapper: N-bit level to RGB via palette, pixel CE and 2-clock aligned sync/blank
//   clk_sys, Reset_I (async active-low)
//   level_i, hs_i, vs_i, hblank_i, vblank_i   core video in
//   pal_wr_i, pal_addr_i, pal_data_i          palette write port ({R,G,B})
//   ce_pix_o                                  pixel enable every CE_DIV clocks
//   r_o, g_o, b_o, hs_o, vs_o, hblank_o, vblank_o, de_o   video out, 2-clock latency
//   pal_pending_o                             uncommitted palette writes exist
// Macro MONO_VIDEO_PAL_LOAD_EN enables the loadable palette; otherwise the
// palette is the constant default ramp and pal_* inputs are ignored.
module mono_video_mapper
    import mono_video_pkg::*;
#(
    parameter int LEVEL_BITS = 2,
    parameter int OUT_BITS   = 8,
    parameter int CE_DIV     = 8
) (
    input  logic                  clk_sys,
    input  logic                  Reset_I,
    input  logic [LEVEL_BITS-1:0] level_i,
    input  logic                  hs_i,
    input  logic                  vs_i,
    input  logic                  hblank_i,
    input  logic                  vblank_i,
    input  logic                  pal_wr_i,
    input  logic [LEVEL_BITS-1:0] pal_addr_i,
    input  logic [3*OUT_BITS-1:0] pal_data_i,
    output logic                  ce_pix_o,
    output logic [OUT_BITS-1:0]   r_o,
    output logic [OUT_BITS-1:0]   g_o,
    output logic [OUT_BITS-1:0]   b_o,
    output logic                  hs_o,
    output logic                  vs_o,
    output logic                  hblank_o,
    output logic                  vblank_o,
    output logic                  de_o,
    output logic                  pal_pending_o
);
    localparam int NE = 2**LEVEL_BITS;
    localparam int RW = 3*OUT_BITS;
    localparam int CW = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
    localparam bit CE_DIV_OK = CE_DIV >= 1;

    if (!CE_DIV_OK) begin : g_bad_ce_div
        $error("mono_video_mapper: CE_DIV must be >= 1");
    end

    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  ce_q, ce_d;
    logic [LEVEL_BITS-1:0] lvl1_q, lvl1_d;
    logic                  hs1_q, hs1_d, vs1_q, vs1_d, hb1_q, hb1_d, vb1_q, vb1_d;
    logic [RW-1:0]         rgb2_q, rgb2_d;
    logic                  hs2_q, hs2_d, vs2_q, vs2_d, hb2_q, hb2_d, vb2_q, vb2_d, de2_q, de2_d;
    logic [RW-1:0]         pal_rgb;

`ifdef MONO_VIDEO_PAL_LOAD_EN
    mono_pal_bank #(
        .LEVEL_BITS(LEVEL_BITS),
        .OUT_BITS  (OUT_BITS)
    ) u_bank (
        .clk_sys   (clk_sys),
        .Reset_I   (Reset_I),
        .vb_edge_i (vblank_i & ~vb1_q),
        .pal_wr_i  (pal_wr_i),
        .pal_addr_i(pal_addr_i),
        .pal_data_i(pal_data_i),
        .rd_level_i(lvl1_q),
        .rd_rgb_o  (pal_rgb),
        .pending_o (pal_pending_o)
    );
`else
    logic [RW-1:0] ramp [NE];
    logic          pal_unused;
    for (genvar g = 0; g < NE; g++) begin : g_ramp
        assign ramp[g] = {3{OUT_BITS'(default_ramp(g, LEVEL_BITS, OUT_BITS))}};
    end
    assign pal_rgb       = ramp[lvl1_q];
    assign pal_pending_o = 1'b0;
    assign pal_unused    = ^{pal_wr_i, pal_addr_i, pal_data_i};
`endif

    // The pipeline runs every clk_sys; ce only marks pixel slots downstream.
    always_comb begin
        cnt_d  = (cnt_q == CW'(CE_DIV-1)) ? '0 : cnt_q + 1'b1;
        ce_d   = cnt_q == '0;
        lvl1_d = level_i;
        hs1_d  = hs_i;
        vs1_d  = vs_i;
        hb1_d  = hblank_i;
        vb1_d  = vblank_i;
        rgb2_d = (hb1_q | vb1_q) ? '0 : pal_rgb;
        hs2_d  = hs1_q;
        vs2_d  = vs1_q;
        hb2_d  = hb1_q;
        vb2_d  = vb1_q;
        de2_d  = ~(hb1_q | vb1_q);
    end

    always_ff @(posedge clk_sys or negedge Reset_I) begin
        if (!Reset_I) begin
            cnt_q  <= '0;
            ce_q   <= 1'b0;
            lvl1_q <= '0;
            hs1_q  <= 1'b0;
            vs1_q  <= 1'b0;
            hb1_q  <= 1'b0;
            vb1_q  <= 1'b0;
            rgb2_q <= '0;
            hs2_q  <= 1'b0;
            vs2_q  <= 1'b0;
            hb2_q  <= 1'b0;
            vb2_q  <= 1'b0;
            de2_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            ce_q   <= ce_d;
            lvl1_q <= lvl1_d;
            hs1_q  <= hs1_d;
            vs1_q  <= vs1_d;
            hb1_q  <= hb1_d;
            vb1_q  <= vb1_d;
            rgb2_q <= rgb2_d;
            hs2_q  <= hs2_d;
            vs2_q  <= vs2_d;
            hb2_q  <= hb2_d;
            vb2_q  <= vb2_d;
            de2_q  <= de2_d;
        end
    end

    assign ce_pix_o = ce_q;
    assign r_o      = rgb2_q[RW-1 -: OUT_BITS];
    assign g_o      = rgb2_q[2*OUT_BITS-1 -: OUT_BITS];
    assign b_o      = rgb2_q[OUT_BITS-1:0];
    assign hs_o     = hs2_q;
    assign vs_o     = vs2_q;
    assign hblank_o = hb2_q;
    assign vblank_o = vb2_q;
    assign de_o     = de2_q;

endmodule

// File: tb/tb_mono_video_mapper.sv
// tb_mono_video_mapper: directed and random checks of mono_video_mapper against a palette model
module tb_mono_video_mapper;
    import mono_video_pkg::*;

    localparam int NE = 4;
`ifdef MONO_VIDEO_PAL_LOAD_EN
    localparam bit PAL_EN = 1'b1;
`else
    localparam bit PAL_EN = 1'b0;
`endif

    logic        clk_sys = 1'b0;
    logic        Reset_I = 1'b0;
    logic [1:0]  level_i = '0;
    logic        hs_i = 1'b0, vs_i = 1'b0, hblank_i = 1'b0, vblank_i = 1'b0, pal_wr_i = 1'b0;
    logic [1:0]  pal_addr_i = '0;
    logic [23:0] pal_data_i = '0;
    logic        ce_pix_o, hs_o, vs_o, hblank_o, vblank_o, de_o, pal_pending_o;
    logic [7:0]  r_o, g_o, b_o;
    logic        ce1_o;
    logic [7:0]  unused_r1, unused_g1, unused_b1;
    logic        unused_hs1, unused_vs1, unused_hb1, unused_vb1, unused_de1, unused_pp1;

    mono_video_mapper #(.LEVEL_BITS(2), .OUT_BITS(8), .CE_DIV(8)) dut (
        .clk_sys(clk_sys), .Reset_I(Reset_I), .level_i(level_i), .hs_i(hs_i), .vs_i(vs_i),
        .hblank_i(hblank_i), .vblank_i(vblank_i), .pal_wr_i(pal_wr_i), .pal_addr_i(pal_addr_i),
        .pal_data_i(pal_data_i), .ce_pix_o(ce_pix_o), .r_o(r_o), .g_o(g_o), .b_o(b_o),
        .hs_o(hs_o), .vs_o(vs_o), .hblank_o(hblank_o), .vblank_o(vblank_o), .de_o(de_o),
        .pal_pending_o(pal_pending_o)
    );

    mono_video_mapper #(.LEVEL_BITS(2), .OUT_BITS(8), .CE_DIV(1)) dut_ce1 (
        .clk_sys(clk_sys), .Reset_I(Reset_I), .level_i(level_i), .hs_i(hs_i), .vs_i(vs_i),
        .hblank_i(hblank_i), .vblank_i(vblank_i), .pal_wr_i(pal_wr_i), .pal_addr_i(pal_addr_i),
        .pal_data_i(pal_data_i), .ce_pix_o(ce1_o), .r_o(unused_r1), .g_o(unused_g1), .b_o(unused_b1),
        .hs_o(unused_hs1), .vs_o(unused_vs1), .hblank_o(unused_hb1), .vblank_o(unused_vb1),
        .de_o(unused_de1), .pal_pending_o(unused_pp1)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct packed {
        rgb_t c;
        logic hs, vs, hb, vb, de;
    } vid_t;

    int   n_chk = 0, n_fail = 0;
    rgb_t act_m [NE];
    rgb_t sh_m  [NE];
    bit   pend_m, vbp_m;
    int   edges;
    vid_t st1_m, exp_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic rgb_t gray(input int i);
        int v;
        v = i * 255 / 3;
        return {8'(v), 8'(v), 8'(v)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NE; i++) begin
            act_m[i] = gray(i);
            sh_m[i]  = gray(i);
        end
        pend_m = 1'b0;
        vbp_m  = 1'b0;
        edges  = 0;
        exp_m  = '0;
        st1_m  = {act_m[0], 5'b00001};
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_rgb"}, {r_o, g_o, b_o}, 24'h0);
        chk({tag, "_sync"}, {hs_o, vs_o, hblank_o, vblank_o, de_o}, 5'b0);
        chk({tag, "_pend"}, pal_pending_o, 1'b0);
        chk({tag, "_ce"}, {ce_pix_o, ce1_o}, 2'b00);
    endtask

    task automatic check_all();
        chk("r", r_o, exp_m.c.r);
        chk("g", g_o, exp_m.c.g);
        chk("b", b_o, exp_m.c.b);
        chk("ctl", {hs_o, vs_o, hblank_o, vblank_o, de_o},
            {exp_m.hs, exp_m.vs, exp_m.hb, exp_m.vb, exp_m.de});
        chk("pend", pal_pending_o, pend_m);
        chk("ce", ce_pix_o, (edges - 1) % 8 == 0);
        chk("ce1", ce1_o, 1'b1);
    endtask

    // One clock: palette edits apply at this edge, the pixel sampled now leaves one edge later.
    task automatic step();
        bit blank;
        @(posedge clk_sys);
        exp_m = st1_m;
        edges++;
        if (PAL_EN) begin
            if (pal_wr_i) sh_m[pal_addr_i] = pal_data_i;
            if (vblank_i && !vbp_m && (pend_m || pal_wr_i)) begin
                act_m  = sh_m;
                pend_m = 1'b0;
            end else if (pal_wr_i) begin
                pend_m = 1'b1;
            end
        end
        vbp_m = vblank_i;
        blank = hblank_i | vblank_i;
        st1_m = {blank ? 24'h0 : act_m[level_i], hs_i, vs_i, hblank_i, vblank_i, ~blank};
        #1;
        check_all();
    endtask

    initial begin
        Reset_I = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1;
        model_reset();
        check_reset("reset");
        @(negedge clk_sys);
        Reset_I = 1'b1;

        for (int i = 1; i <= 17; i++) begin
            level_i = 2'(i % 4);
            step();
            chk("ce_cycle", ce_pix_o, (i == 1 || i == 9 || i == 17));
        end

        level_i = 2'd3; step(); step();
        chk("gray3", {r_o, g_o, b_o}, 24'hFFFFFF);
        level_i = 2'd2; step(); step();
        chk("gray2", {r_o, g_o, b_o}, 24'hAAAAAA);
        level_i = 2'd0; step(); step();
        chk("gray0", {r_o, g_o, b_o}, 24'h000000);
        level_i = 2'd1; step();
        chk("lat_old", {r_o, g_o, b_o}, 24'h000000);
        step();
        chk("gray1", {r_o, g_o, b_o}, 24'h555555);

        hblank_i = 1'b1; level_i = 2'd3; hs_i = 1'b1; step();
        chk("hb_lat1", {hblank_o, hs_o, de_o}, 3'b001);
        step();
        chk("hb_rgb", {r_o, g_o, b_o}, 24'h0);
        chk("hb_ctl", {hblank_o, hs_o, de_o}, 3'b110);
        hblank_i = 1'b0; hs_i = 1'b0; vs_i = 1'b1; step();
        chk("vs_lat1", vs_o, 1'b0);
        step();
        chk("vs_lat2", vs_o, 1'b1);
        vs_i = 1'b0;

        level_i = 2'd1; pal_wr_i = 1'b1; pal_addr_i = 2'd1; pal_data_i = 24'hFF0000; step();
        pal_wr_i = 1'b0; step(); step(); step();
        chk("wr_pend", pal_pending_o, PAL_EN);
        chk("wr_nocommit", {r_o, g_o, b_o}, 24'h555555);
        vblank_i = 1'b1; step();
        chk("vb_commit_pend", pal_pending_o, 1'b0);
        vblank_i = 1'b0; step(); step();
        chk("commit_rgb", {r_o, g_o, b_o}, PAL_EN ? 24'hFF0000 : 24'h555555);

        level_i = 2'd2; pal_wr_i = 1'b1; pal_addr_i = 2'd2; pal_data_i = 24'h00FF00; vblank_i = 1'b1;
        step();
        pal_wr_i = 1'b0;
        chk("bypass_pend", pal_pending_o, 1'b0);
        vblank_i = 1'b0; step(); step();
        chk("bypass_rgb", {r_o, g_o, b_o}, PAL_EN ? 24'h00FF00 : 24'hAAAAAA);

        pal_wr_i = 1'b1; pal_addr_i = 2'd3; pal_data_i = 24'h123456; step();
        pal_wr_i = 1'b0;
        chk("pre_rst_pend", pal_pending_o, PAL_EN);
        level_i = 2'd3; step();
        #2;
        Reset_I = 1'b0;
        #1;
        model_reset();
        check_reset("midrst");
        @(negedge clk_sys);
        Reset_I = 1'b1;
        level_i = 2'd1; step(); step();
        chk("post_rst_gray1", {r_o, g_o, b_o}, 24'h555555);
        level_i = 2'd3; vblank_i = 1'b1; step();
        vblank_i = 1'b0; step(); step();
        chk("post_rst_gray3", {r_o, g_o, b_o}, 24'hFFFFFF);

        for (int i = 0; i < 400; i++) begin
            level_i    = 2'($urandom_range(0, 3));
            hs_i       = 1'($urandom_range(0, 1));
            vs_i       = 1'($urandom_range(0, 1));
            hblank_i   = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) vblank_i = ~vblank_i;
            pal_wr_i   = ($urandom_range(0, 2) == 0);
            pal_addr_i = 2'($urandom_range(0, 3));
            pal_data_i = 24'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
